// File: rtl/decode_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue_if
//  Description : Fetch-side and decode-side handshake bundle for decode_queue.
//                master = fetch/consumer environment, slave = the queue.
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             flush_i;
  logic             instr_valid_i;
  logic [31:0]      instr_i;
  logic [PC_W-1:0]  pc_i;
  logic             instr_ready_o;
  logic             dec_valid_o;
  logic             dec_ready_i;
  logic [PC_W-1:0]  pc_dec_o;
  logic [5:0]       op_dec_o;
  logic [4:0]       rs_dec_o;
  logic [4:0]       rt_dec_o;
  logic [4:0]       rd_dec_o;
  logic [4:0]       shamt_dec_o;
  logic [5:0]       funct_dec_o;
  logic [25:0]      target_dec_o;
  logic [31:0]      imm_dec_o;
  logic [4:0]       dest_dec_o;
  logic             reg_wr_dec_o;
  logic [CNT_W-1:0] count_o;

  modport master (
    output flush_i, instr_valid_i, instr_i, pc_i, dec_ready_i,
    input  instr_ready_o, dec_valid_o, pc_dec_o, op_dec_o, rs_dec_o,
           rt_dec_o, rd_dec_o, shamt_dec_o, funct_dec_o, target_dec_o,
           imm_dec_o, dest_dec_o, reg_wr_dec_o, count_o
  );

  modport slave (
    input  flush_i, instr_valid_i, instr_i, pc_i, dec_ready_i,
    output instr_ready_o, dec_valid_o, pc_dec_o, op_dec_o, rs_dec_o,
           rt_dec_o, rd_dec_o, shamt_dec_o, funct_dec_o, target_dec_o,
           imm_dec_o, dest_dec_o, reg_wr_dec_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue
//  Description : Buffered MIPS decode stage. A DEPTH-entry FIFO of
//                {instruction, PC} with full combinational decode of the
//                head entry, back-pressure and flush.
//                Optional macro DECODE_BYPASS_EN: when the queue is empty an
//                offered instruction is decoded straight onto the outputs in
//                the same cycle (consumed without a write if accepted).
//  Revision    : 1.0  initial release
// ============================================================================
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      instr_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             queue_ready;
  logic             queue_valid;
  logic             bypass;
  logic             push;
  logic             pop;

  logic             head_valid;
  logic [31:0]      head_instr;
  logic [PC_W-1:0]  head_pc;

  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       funct;
  logic [25:0]      target;
  logic [31:0]      imm;
  logic [4:0]       dest;
  logic             wr_raw;

  // Readiness depends only on registered occupancy, never on dec_ready_i.
  always_comb begin
    queue_ready = (count < CNT_W'(DEPTH));
    queue_valid = (count != '0);
  end

  // Head source selection: queue head, or the live input when bypassing.
`ifdef DECODE_BYPASS_EN
  always_comb begin
    bypass     = (count == '0) && bus.instr_valid_i && !bus.flush_i;
    head_valid = queue_valid || bypass;
    head_instr = bypass ? bus.instr_i : instr_mem[rd_ptr];
    head_pc    = bypass ? bus.pc_i    : pc_mem[rd_ptr];
  end
`else
  always_comb begin
    bypass     = 1'b0;
    head_valid = queue_valid;
    head_instr = instr_mem[rd_ptr];
    head_pc    = pc_mem[rd_ptr];
  end
`endif

  // Handshake qualification; a bypassed-and-accepted instruction is never stored.
  always_comb begin
    push = bus.instr_valid_i && queue_ready && !bus.flush_i
           && !(bypass && bus.dec_ready_i);
    pop  = queue_valid && bus.dec_ready_i && !bus.flush_i;
  end

  // Pointer and occupancy bookkeeping; reset outranks flush.
  always_ff @(posedge clk) begin
    if (reset || bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.instr_i;
      pc_mem[wr_ptr]    <= bus.pc_i;
    end
  end

  // Raw field extraction and opcode-dependent immediate/destination decode.
  always_comb begin
    op     = head_instr[31:26];
    rs     = head_instr[25:21];
    rt     = head_instr[20:16];
    rd     = head_instr[15:11];
    shamt  = head_instr[10:6];
    funct  = head_instr[5:0];
    target = head_instr[25:0];

    case (op)
      6'h0C, 6'h0D, 6'h0E: imm = {16'h0000, head_instr[15:0]};
      6'h0F:               imm = {head_instr[15:0], 16'h0000};
      default:             imm = {{16{head_instr[15]}}, head_instr[15:0]};
    endcase

    case (op)
      6'h00:   dest = rd;
      6'h03:   dest = 5'd31;
      default: dest = rt;
    endcase

    // jr never writes; jalr with rd=0 is also dropped by the dest check below.
    case (op)
      6'h00:   wr_raw = !((funct == 6'h08) || ((funct == 6'h09) && (rd == 5'd0)));
      6'h03:   wr_raw = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:   wr_raw = 1'b1;
      6'h20, 6'h21, 6'h22,
      6'h23, 6'h24, 6'h25:          wr_raw = 1'b1;
      default: wr_raw = 1'b0;
    endcase
  end

  // Output drive; every decoded field reads zero while nothing is valid.
  always_comb begin
    bus.instr_ready_o = queue_ready;
    bus.dec_valid_o   = head_valid;
    bus.count_o       = count;
    bus.pc_dec_o      = '0;
    bus.op_dec_o      = '0;
    bus.rs_dec_o      = '0;
    bus.rt_dec_o      = '0;
    bus.rd_dec_o      = '0;
    bus.shamt_dec_o   = '0;
    bus.funct_dec_o   = '0;
    bus.target_dec_o  = '0;
    bus.imm_dec_o     = '0;
    bus.dest_dec_o    = '0;
    bus.reg_wr_dec_o  = 1'b0;
    if (head_valid) begin
      bus.pc_dec_o     = head_pc;
      bus.op_dec_o     = op;
      bus.rs_dec_o     = rs;
      bus.rt_dec_o     = rt;
      bus.rd_dec_o     = rd;
      bus.shamt_dec_o  = shamt;
      bus.funct_dec_o  = funct;
      bus.target_dec_o = target;
      bus.imm_dec_o    = imm;
      bus.dest_dec_o   = dest;
      bus.reg_wr_dec_o = wr_raw && (dest != 5'd0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_queue
//  Description : Self-checking bench for decode_queue: directed scenarios
//                followed by randomized traffic against a queue-based model.
//                Honours DECODE_BYPASS_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;
  entry_t mq[$];

  decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus();

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode rules written directly from the ISA field definitions.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [5:0] o = ins[31:26];
    if (o == 6'h0C || o == 6'h0D || o == 6'h0E) return {16'h0, ins[15:0]};
    if (o == 6'h0F) return {ins[15:0], 16'h0};
    return 32'(signed'(ins[15:0]));
  endfunction

  function automatic logic [4:0] ref_dest(input logic [31:0] ins);
    if (ins[31:26] == 6'h00) return ins[15:11];
    if (ins[31:26] == 6'h03) return 5'd31;
    return ins[20:16];
  endfunction

  function automatic bit ref_wr(input logic [31:0] ins);
    int o = int'(ins[31:26]);
    int f = int'(ins[5:0]);
    bit w;
    w = (o == 0 && f != 8 && !(f == 9 && ins[15:11] == 0)) ||
        (o >= 8 && o <= 15) || (o >= 32 && o <= 37) || (o == 3);
    return w && (ref_dest(ins) != 0);
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] p,
                       input bit rdy, input bit fl);
    bus.instr_valid_i = v;
    bus.instr_i       = ins;
    bus.pc_i          = p;
    bus.dec_ready_i   = rdy;
    bus.flush_i       = fl;
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic step();
    bit     byp, v, do_push, do_pop;
    entry_t h;
    @(negedge clk);
    byp = BYP && mq.size() == 0 && bus.instr_valid_i && !bus.flush_i;
    v   = (mq.size() != 0) || byp;
    h   = byp ? entry_t'{bus.instr_i, bus.pc_i} : (mq.size() != 0 ? mq[0] : '0);
    check("count",  64'(bus.count_o),       64'(mq.size()));
    check("ready",  64'(bus.instr_ready_o), 64'(mq.size() < DEPTH));
    check("valid",  64'(bus.dec_valid_o),   64'(v));
    check("pc",     64'(bus.pc_dec_o),      v ? 64'(h.pc) : 64'd0);
    check("op",     64'(bus.op_dec_o),      v ? 64'(h.ins[31:26]) : 64'd0);
    check("rs",     64'(bus.rs_dec_o),      v ? 64'(h.ins[25:21]) : 64'd0);
    check("rt",     64'(bus.rt_dec_o),      v ? 64'(h.ins[20:16]) : 64'd0);
    check("rd",     64'(bus.rd_dec_o),      v ? 64'(h.ins[15:11]) : 64'd0);
    check("shamt",  64'(bus.shamt_dec_o),   v ? 64'(h.ins[10:6]) : 64'd0);
    check("funct",  64'(bus.funct_dec_o),   v ? 64'(h.ins[5:0]) : 64'd0);
    check("target", 64'(bus.target_dec_o),  v ? 64'(h.ins[25:0]) : 64'd0);
    check("imm",    64'(bus.imm_dec_o),     v ? 64'(ref_imm(h.ins)) : 64'd0);
    check("dest",   64'(bus.dest_dec_o),    v ? 64'(ref_dest(h.ins)) : 64'd0);
    check("reg_wr", 64'(bus.reg_wr_dec_o),  v ? 64'(ref_wr(h.ins)) : 64'd0);
    do_push = bus.instr_valid_i && mq.size() < DEPTH && !bus.flush_i && !(byp && bus.dec_ready_i);
    do_pop  = mq.size() != 0 && bus.dec_ready_i && !bus.flush_i;
    @(posedge clk);
    #1;
    if (reset || bus.flush_i) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(entry_t'{bus.instr_i, bus.pc_i});
    end
  endtask

  task automatic push_hold(input logic [31:0] ins, input logic [31:0] p);
    drive(1'b1, ins, p, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: begin
        r[31:26] = 6'h00;
        case ($urandom_range(0, 3))
          0: r[5:0] = 6'h08;
          1: r[5:0] = 6'h09;
          default: r[5:0] = 6'h20;
        endcase
        if ($urandom_range(0, 3) == 0) r[15:11] = 5'd0;
      end
      1: r[31:26] = 6'h03;
      2: r[31:26] = 6'($urandom_range(8, 15));
      3: r[31:26] = 6'($urandom_range(32, 37));
      default: ;
    endcase
    if ($urandom_range(0, 4) == 0) r[20:16] = 5'd0;
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    check("rst_count", 64'(bus.count_o), 64'd0);
    check("rst_ready", 64'(bus.instr_ready_o), 64'd1);
    check("rst_valid", 64'(bus.dec_valid_o), 64'd0);

    // add $3,$1,$2
    push_hold(32'h00221820, 32'h100);
    check("add_valid", 64'(bus.dec_valid_o), 64'd1);
    check("add_rs", 64'(bus.rs_dec_o), 64'd1);
    check("add_rt", 64'(bus.rt_dec_o), 64'd2);
    check("add_rd", 64'(bus.rd_dec_o), 64'd3);
    check("add_funct", 64'(bus.funct_dec_o), 64'h20);
    check("add_dest", 64'(bus.dest_dec_o), 64'd3);
    check("add_wr", 64'(bus.reg_wr_dec_o), 64'd1);
    check("add_pc", 64'(bus.pc_dec_o), 64'h100);
    pop_one();

    push_hold(32'h2128FFFF, 32'h104);
    check("addi_imm", 64'(bus.imm_dec_o), 64'hFFFFFFFF);
    check("addi_dest", 64'(bus.dest_dec_o), 64'd8);
    pop_one();
    push_hold(32'h3528FFFF, 32'h108);
    check("ori_imm", 64'(bus.imm_dec_o), 64'h0000FFFF);
    check("ori_dest", 64'(bus.dest_dec_o), 64'd8);
    pop_one();
    push_hold(32'h3C081234, 32'h10C);
    check("lui_imm", 64'(bus.imm_dec_o), 64'h12340000);
    check("lui_dest", 64'(bus.dest_dec_o), 64'd8);
    pop_one();

    push_hold(32'h0C000010, 32'h110);
    check("jal_target", 64'(bus.target_dec_o), 64'h10);
    check("jal_dest", 64'(bus.dest_dec_o), 64'd31);
    check("jal_wr", 64'(bus.reg_wr_dec_o), 64'd1);
    pop_one();
    push_hold(32'h03E00008, 32'h114);
    check("jr_wr", 64'(bus.reg_wr_dec_o), 64'd0);
    pop_one();

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, rand_instr(), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // Fill to full, refused push during a pop, then drain in order.
    for (int i = 0; i < DEPTH; i++) push_hold(32'h20000000 + 32'(i), 32'h300 + 32'(4 * i));
    check("full_count", 64'(bus.count_o), 64'(DEPTH));
    check("full_ready", 64'(bus.instr_ready_o), 64'd0);
    drive(1'b1, 32'h2000BEEF, 32'h3F0, 1'b1, 1'b0);
    step();
    check("refused_count", 64'(bus.count_o), 64'(DEPTH - 1));
    for (int i = 0; i < DEPTH + 1; i++) pop_one();
    check("drain_count", 64'(bus.count_o), 64'd0);

    // Flush with three queued and a concurrent push.
    for (int i = 0; i < 3; i++) push_hold(32'h24000000 + 32'(i), 32'h400 + 32'(4 * i));
    drive(1'b1, 32'h2400AAAA, 32'h40C, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("flush_count", 64'(bus.count_o), 64'd0);
    check("flush_valid", 64'(bus.dec_valid_o), 64'd0);
    check("flush_pc", 64'(bus.pc_dec_o), 64'd0);
    step();

    // Reset with two queued and a push pending.
    push_hold(32'h24010001, 32'h500);
    push_hold(32'h24020002, 32'h504);
    drive(1'b1, 32'h24030003, 32'h508, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset_count", 64'(bus.count_o), 64'd0);
    check("reset_ready", 64'(bus.instr_ready_o), 64'd1);
    step();

`ifdef DECODE_BYPASS_EN
    drive(1'b1, 32'h00221820, 32'h600, 1'b1, 1'b0);
    #1;
    check("byp_valid", 64'(bus.dec_valid_o), 64'd1);
    check("byp_rd", 64'(bus.rd_dec_o), 64'd3);
    check("byp_pc", 64'(bus.pc_dec_o), 64'h600);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("byp_count", 64'(bus.count_o), 64'd0);
    step();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step();
    check("final_count", 64'(bus.count_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, handshaked instruction decode stage between fetch and register read.
- Holds up to DEPTH fetched instructions with their PCs in a FIFO.
- Fully decodes the head entry: register fields, opcode-dependent immediate extension, destination register select and register-write flag.
- Supports back-pressure from the pipeline and flush on redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- PC_W, 32, width of the PC carried alongside each instruction.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush_i  input  1  discard all queued entries.
- instr_valid_i  input  1  fetch offers an instruction.
- instr_i  input  32  raw MIPS instruction.
- pc_i  input  PC_W  PC of instr_i.
- instr_ready_o  output  1  queue can accept.
- dec_valid_o  output  1  decoded head entry valid.
- dec_ready_i  input  1  consumer accepts head.
- pc_dec_o  output  PC_W  PC of head entry.
- op_dec_o  output  6  instr[31:26].
- rs_dec_o  output  5  instr[25:21].
- rt_dec_o  output  5  instr[20:16].
- rd_dec_o  output  5  instr[15:11].
- shamt_dec_o  output  5  instr[10:6].
- funct_dec_o  output  6  instr[5:0].
- target_dec_o  output  26  instr[25:0].
- imm_dec_o  output  32  extended immediate.
- dest_dec_o  output  5  architectural destination register.
- reg_wr_dec_o  output  1  instruction writes a register.
- count_o  output  CNT_W  current occupancy.

Behaviour:
- Reset: read/write pointers 0, count_o=0, instr_ready_o=1, dec_valid_o=0. Storage contents are not reset.
- Push when instr_valid_i & instr_ready_o & !flush_i. Pop when dec_valid_o & dec_ready_i & !flush_i.
- instr_ready_o = (count_o < DEPTH). It is registered-state only, with no combinational path from dec_ready_i. A push is therefore refused when full even if a pop happens in the same cycle.
- dec_valid_o = (count_o != 0).
- Latency: an entry pushed at edge N is presented at the head after edge N. Minimum fetch-to-decode latency is 1 cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Ordering is strict FIFO.
- Consumer contract: fields must stay stable while dec_valid_o=1 and dec_ready_i=0.
- flush_i: at the next edge, count=0 and pointers=0. Any same-cycle push and pop are discarded. Reset has priority over flush.
- All decoded outputs and pc_dec_o are forced to 0 while dec_valid_o=0.
- Field outputs are combinational decode of the head slot.
- imm_dec_o:
  - op 0x0C/0x0D/0x0E (andi/ori/xori): zero-extend instr[15:0].
  - op 0x0F (lui): {instr[15:0],16'h0}.
  - all other ops: sign-extend instr[15:0].
- dest_dec_o: op 0x00 → rd; op 0x03 (jal) → 5'd31; else rt.
- reg_wr_dec_o = 1 for:
  - op 0x00 except funct 0x08 (jr) and funct 0x09 with rd=0;
  - op 0x08–0x0F;
  - op 0x20–0x25;
  - op 0x03.
  Otherwise 0. Independent of the above, reg_wr_dec_o=0 whenever dest_dec_o=0.

Optional Feature:
- Macro DECODE_BYPASS_EN.
- Defined: when count_o=0, instr_valid_i=1 and !flush_i, the input is decoded combinationally onto the outputs in the same cycle, with dec_valid_o=1.
  - If dec_ready_i=1, the instruction is consumed without being written to the FIFO (zero latency).
  - Otherwise it is pushed normally.
- Undefined: no input-to-output combinational path; minimum latency is 1 cycle.

Test Plan:
- Push 0x00221820 (add $3,$1,$2), pc 0x100 → next cycle dec_valid_o=1, rs=1, rt=2, rd=3, funct=0x20, dest=3, reg_wr=1, pc_dec_o=0x100.
- Push 0x2128FFFF (addi), then 0x3528FFFF (ori), then 0x3C081234 (lui), dec_ready_i=1 → imm_dec_o = 0xFFFFFFFF, 0x0000FFFF, 0x12340000 in order; dest=8 for each.
- Push 0x0C000010 (jal) → target_dec_o=0x10, dest=31, reg_wr=1. Push 0x03E00008 (jr $31) → reg_wr=0.
- Hold dec_ready_i=0 and push DEPTH instructions → count_o=DEPTH, instr_ready_o=0. The 5th push is refused even with dec_ready_i=1 that cycle. Drain → original order preserved, pointers wrap correctly.
- With 3 entries queued, assert flush_i together with instr_valid_i → next cycle count_o=0, dec_valid_o=0, outputs 0, flushed-cycle instruction absent.
- Reset asserted with 2 entries queued and a push pending → count_o=0, instr_ready_o=1 next cycle. With DECODE_BYPASS_EN on an empty queue and dec_ready_i=1, push 0x00221820 → dec_valid_o=1 the same cycle, count_o stays 0.
